// File: rtl/pong_fb_painter.sv
// Frame-buffer writer for the two-paddle game: clears the pixel RAM, then repaints both paddle columns each frame tick.
// Optional build macro PONG_FB_SKIP_UNCHANGED_EN skips repainting a paddle column whose position did not change.
module pong_fb_painter #(
  parameter int            SCREEN_X    = 176,
  parameter int            SCREEN_Y    = 120,
  parameter int            AW          = 15,
  parameter int            DW          = 3,
  parameter int            PAD_H       = 24,
  parameter int            PAD_STEP    = 2,
  parameter int            PAD_A_X     = 4,
  parameter int            PAD_B_X     = 171,
  parameter logic [DW-1:0] BG_COLOR    = 3'b000,
  parameter logic [DW-1:0] PAD_A_COLOR = 3'b100,
  parameter logic [DW-1:0] PAD_B_COLOR = 3'b001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          btn_up_a,
  input  logic          btn_dn_a,
  input  logic          btn_up_b,
  input  logic          btn_dn_b,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy
);

  localparam int YW = $clog2(SCREEN_Y);

  localparam logic [AW-1:0]        LAST_ADDR = AW'(SCREEN_X * SCREEN_Y - 1);
  localparam logic [AW-1:0]        ROW_STEP  = AW'(SCREEN_X);
  localparam logic [AW-1:0]        COL_A     = AW'(PAD_A_X);
  localparam logic [AW-1:0]        COL_B     = AW'(PAD_B_X);
  localparam logic [YW-1:0]        Y_LAST    = YW'(SCREEN_Y - 1);
  localparam logic [YW-1:0]        CENTER    = YW'((SCREEN_Y - PAD_H) / 2);
  localparam logic [YW:0]          PAD_H_W   = (YW+1)'(PAD_H);
  localparam logic signed [AW:0]   STEP_S    = (AW+1)'(PAD_STEP);
  localparam logic signed [AW:0]   POS_MAX_S = (AW+1)'(SCREEN_Y - PAD_H);

  typedef enum logic [2:0] {CLEAR, DRAW_A, DRAW_B, IDLE, UPDATE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] row_addr;
  logic [YW-1:0] y;
  logic [YW-1:0] pos_a, pos_b;
  logic [YW-1:0] pos_a_upd, pos_b_upd;
  logic          last_clear, last_row;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
  logic          chg_a, chg_b;
`endif

  // Wider signed arithmetic so moving up from row 0 cannot wrap to a large position.
  function automatic logic [YW-1:0] next_pos(input logic [YW-1:0] pos,
                                             input logic up, input logic dn);
    logic signed [AW:0] p;
    logic signed [AW:0] t;
    p = $signed({{(AW+1-YW){1'b0}}, pos});
    t = p;
    if (up && !dn) begin
      t = p - STEP_S;
      if (t[AW]) t = '0;
    end else if (dn && !up) begin
      t = p + STEP_S;
      if (t > POS_MAX_S) t = POS_MAX_S;
    end
    return YW'(t);
  endfunction

  function automatic logic [DW-1:0] pad_pixel(input logic [YW-1:0] row,
                                              input logic [YW-1:0] pos,
                                              input logic [DW-1:0] col);
    logic [YW:0] top;
    top = {1'b0, pos} + PAD_H_W;
    return (({1'b0, row} >= {1'b0, pos}) && ({1'b0, row} < top)) ? col : BG_COLOR;
  endfunction

  assign pos_a_upd  = next_pos(pos_a, btn_up_a, btn_dn_a);
  assign pos_b_upd  = next_pos(pos_b, btn_up_b, btn_dn_b);
  assign last_clear = (cnt == LAST_ADDR);
  assign last_row   = (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:  if (last_clear) state_nxt = DRAW_A;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
      DRAW_A: if (last_row) state_nxt = chg_b ? DRAW_B : IDLE;
`else
      DRAW_A: if (last_row) state_nxt = DRAW_B;
`endif
      DRAW_B: if (last_row) state_nxt = IDLE;
      IDLE:   if (frame_tick) state_nxt = UPDATE;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
      UPDATE: begin
        if (pos_a_upd != pos_a)      state_nxt = DRAW_A;
        else if (pos_b_upd != pos_b) state_nxt = DRAW_B;
        else                         state_nxt = IDLE;
      end
`else
      UPDATE: state_nxt = DRAW_A;
`endif
      default: state_nxt = CLEAR;
    endcase
  end

  // Write port: every output is registered from the state of the cycle just finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_wr       <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      y           <= '0;
      row_addr    <= COL_A;
      pos_a       <= CENTER;
      pos_b       <= CENTER;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
      chg_a       <= 1'b1;
      chg_b       <= 1'b1;
`endif
    end else begin
      busy  <= (state != IDLE);
      px_wr <= 1'b0;
      case (state)
        CLEAR: begin
          px_wr       <= 1'b1;
          mem_px_addr <= cnt;
          mem_px_data <= BG_COLOR;
          if (last_clear) begin
            cnt      <= '0;
            y        <= '0;
            row_addr <= COL_A;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAW_A: begin
          px_wr       <= 1'b1;
          mem_px_addr <= row_addr;
          mem_px_data <= pad_pixel(y, pos_a, PAD_A_COLOR);
          y           <= last_row ? '0 : y + 1'b1;
          row_addr    <= last_row ? COL_B : row_addr + ROW_STEP;
        end
        DRAW_B: begin
          px_wr       <= 1'b1;
          mem_px_addr <= row_addr;
          mem_px_data <= pad_pixel(y, pos_b, PAD_B_COLOR);
          y           <= last_row ? '0 : y + 1'b1;
          row_addr    <= last_row ? COL_A : row_addr + ROW_STEP;
        end
        UPDATE: begin
          pos_a    <= pos_a_upd;
          pos_b    <= pos_b_upd;
          y        <= '0;
          row_addr <= (state_nxt == DRAW_B) ? COL_B : COL_A;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
          chg_a    <= (pos_a_upd != pos_a);
          chg_b    <= (pos_b_upd != pos_b);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_fb_painter.sv
// Self-checking bench for pong_fb_painter: captures every RAM write and compares against a pixel-level model.
module tb_pong_fb_painter;
  localparam int SX = 176, SY = 120, AW = 15, DW = 3, PH = 24, STEP = 2, AX = 4, BX = 171;
`ifdef PONG_FB_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, frame_tick = 1'b0;
  logic          btn_up_a = 1'b0, btn_dn_a = 1'b0, btn_up_b = 1'b0, btn_dn_b = 1'b0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, busy;

  always #20 clk = ~clk;

  pong_fb_painter dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up_a(btn_up_a), .btn_dn_a(btn_dn_a), .btn_up_b(btn_up_b), .btn_dn_b(btn_dn_b),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr), .busy(busy)
  );

  int checks = 0, errors = 0;
  int pa_m = 48, pb_m = 48;
  int exp_a[$], exp_d[$], got_a[$], got_d[$];
  int busy_cnt, first_wr;
  bit timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int upd(int p, bit up, bit dn);
    if (up && !dn) return (p - STEP < 0) ? 0 : p - STEP;
    if (dn && !up) return (p + STEP > SY - PH) ? SY - PH : p + STEP;
    return p;
  endfunction

  function automatic void add_col(int x, int pos, int col);
    for (int yy = 0; yy < SY; yy++) begin
      exp_a.push_back(yy * SX + x);
      exp_d.push_back((yy >= pos && yy < pos + PH) ? col : 0);
    end
  endfunction

  function automatic int px_at(int addr);
    for (int i = 0; i < got_a.size(); i++) if (got_a[i] == addr) return got_d[i];
    return -1;
  endfunction

  task automatic collect(int limit, int inject_at);
    bit seen = 1'b0;
    got_a.delete(); got_d.delete();
    busy_cnt = 0; first_wr = -1; timed_out = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      frame_tick = (i == inject_at);
      tick();
      if (px_wr) begin
        got_a.push_back(int'(mem_px_addr));
        got_d.push_back(int'(mem_px_data));
        if (first_wr < 0) first_wr = i;
      end
      if (busy) begin
        seen = 1'b1;
        busy_cnt++;
      end else if (seen) begin
        timed_out = 1'b0;
        break;
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic compare_writes(string tag);
    int bad = 0, first = -1;
    check({tag, " write count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL %s pixels: %0d bad, first #%0d got addr %0d data %0d expected addr %0d data %0d",
             tag, bad, first, got_a[first], got_d[first], exp_a[first], exp_d[first]);
    end
  endtask

  task automatic check_clear(string tag);
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < SX * SY; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(0);
    end
    add_col(AX, 48, 4);
    add_col(BX, 48, 1);
    collect(30000, 0);
    check({tag, " finished"}, int'(timed_out), 0);
    check({tag, " first write cycle"}, first_wr, 1);
    check({tag, " busy cycles"}, busy_cnt, SX * SY + 2 * SY);
    compare_writes(tag);
  endtask

  task automatic do_frame(string tag, bit ua, bit da, bit ub, bit db, int inject_at);
    int na, nb;
    bit ca, cb;
    na = upd(pa_m, ua, da);
    nb = upd(pb_m, ub, db);
    ca = (na != pa_m);
    cb = (nb != pb_m);
    pa_m = na;
    pb_m = nb;
    exp_a.delete(); exp_d.delete();
    if (!SKIP || ca) add_col(AX, pa_m, 4);
    if (!SKIP || cb) add_col(BX, pb_m, 1);
    check({tag, " idle before tick"}, int'(busy), 0);
    btn_up_a = ua; btn_dn_a = da; btn_up_b = ub; btn_dn_b = db;
    frame_tick = 1'b1;
    tick();
    collect(400, inject_at);
    btn_up_a = 1'b0; btn_dn_a = 1'b0; btn_up_b = 1'b0; btn_dn_b = 1'b0;
    check({tag, " finished"}, int'(timed_out), 0);
    check({tag, " busy cycles"}, busy_cnt, 1 + exp_a.size());
    if (exp_a.size() > 0) check({tag, " first write latency"}, first_wr, 2);
    compare_writes(tag);
    repeat (3) tick();
    check({tag, " quiet after"}, int'({busy, px_wr}), 0);
  endtask

  initial begin
    int prev, cnt_b;
    bit ub, db;

    rst = 1'b1;
    repeat (3) tick();
    check("reset px_wr", int'(px_wr), 0);
    check("reset addr", int'(mem_px_addr), 0);
    check("reset data", int'(mem_px_data), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    check_clear("clear");

    do_frame("up_a", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_frame("both_a", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_frame("inject", 1'b0, 1'b1, 1'b0, 1'b0, 50);

    for (int k = 0; k < 30; k++) begin
      prev = pb_m;
      do_frame("hold_up_b", 1'b0, 1'b0, 1'b1, 1'b0, 0);
      if (pb_m == 0 && prev != 0) begin
        check("b top row", px_at(BX), 1);
        check("b row 23", px_at(BX + SX * 23), 1);
        check("b row 24", px_at(BX + SX * 24), 0);
      end
    end

    for (int k = 0; k < 40; k++) begin
      prev = pa_m;
      do_frame("hold_dn_a", 1'b0, 1'b1, 1'b0, 1'b0, 0);
      if (pa_m == SY - PH && prev != SY - PH) begin
        check("a row 95", px_at(AX + SX * 95), 0);
        check("a row 96", px_at(AX + SX * 96), 4);
        check("a row 119", px_at(AX + SX * 119), 4);
      end
    end

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_frame("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    db = (pb_m < SY - PH);
    ub = !db;
    btn_up_b = ub; btn_dn_b = db;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cnt_b = 0;
    for (int i = 0; i < 400 && cnt_b < 20; i++) begin
      tick();
      if (px_wr && (int'(mem_px_addr) % SX) == BX) cnt_b++;
    end
    btn_up_b = 1'b0; btn_dn_b = 1'b0;
    check("reached draw_b", cnt_b, 20);
    rst = 1'b1;
    tick();
    check("abort px_wr", int'(px_wr), 0);
    check("abort busy", int'(busy), 0);
    rst = 1'b0;
    pa_m = 48;
    pb_m = 48;
    check_clear("reclear");

    do_frame("no_buttons", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_frame("dn_b_only", 1'b0, 1'b0, 1'b0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_fb_painter.md
Name: pong_fb_painter

Overview:
- Frame-buffer writer for the 2-player paddle game. It drives the write port of the dual-port pixel RAM (176x120, 3-bit RGB), which the VGA driver reads through the scaled address path.
- After reset it clears the buffer and draws two paddles.
- On each frame tick it updates the paddle positions from the buttons and repaints both paddle columns.
- It writes one pixel per clock and never reads the RAM.

Parameters:
- SCREEN_X, 176, buffer width in pixels
- SCREEN_Y, 120, buffer height in pixels
- AW, 15, address width (ceil log2 of SCREEN_X*SCREEN_Y)
- DW, 3, pixel width, RGB 1:1:1
- PAD_H, 24, paddle height in pixels
- PAD_STEP, 2, pixels moved per frame tick
- PAD_A_X, 4, column of paddle A
- PAD_B_X, 171, column of paddle B
- BG_COLOR, 3'b000, background colour
- PAD_A_COLOR, 3'b100, paddle A colour (red)
- PAD_B_COLOR, 3'b001, paddle B colour (blue)

Ports:
- clk  in  1  pixel clock, 25 MHz domain shared with the RAM write port
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse per video frame, already synchronous to clk
- btn_up_a  in  1  paddle A up, level, pre-debounced
- btn_dn_a  in  1  paddle A down, level, pre-debounced
- btn_up_b  in  1  paddle B up, level, pre-debounced
- btn_dn_b  in  1  paddle B down, level, pre-debounced
- mem_px_addr  out  AW  RAM write address, equal to y*SCREEN_X+x
- mem_px_data  out  DW  RAM write data
- px_wr  out  1  RAM write enable, one pixel per cycle while high
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (rst).
- All outputs are registered. Reset values:
  - px_wr=0, mem_px_addr=0, mem_px_data=0, busy=0
  - state=CLEAR
  - pos_a=pos_b=(SCREEN_Y-PAD_H)/2 (48 with defaults)
- States: CLEAR -> DRAW_A -> DRAW_B -> IDLE -> UPDATE -> DRAW_A ...
- CLEAR:
  - The first cycle after rst deasserts presents px_wr=1, addr=0, data=BG_COLOR.
  - Address increments by 1 every cycle through SCREEN_X*SCREEN_Y-1 (21119), i.e. exactly 21120 write cycles.
  - Then goes to DRAW_A.
- DRAW_A / DRAW_B:
  - Row counter y runs 0..SCREEN_Y-1, one write per cycle: SCREEN_Y cycles per column.
  - addr = y*SCREEN_X + PAD_x.
  - data = paddle colour if pos <= y <= pos+PAD_H-1, else BG_COLOR.
  - The address is formed by an incremental add of SCREEN_X per row (no multiplier). Width is truncated to AW, and the maximum value fits.
  - DRAW_A is followed by DRAW_B; DRAW_B is followed by IDLE.
- IDLE:
  - px_wr=0, busy=0; addr and data hold their last values.
  - frame_tick=1 moves to UPDATE on the next cycle.
- UPDATE (1 cycle, px_wr=0):
  - For each paddle: up only gives pos=max(pos-PAD_STEP, 0); down only gives pos=min(pos+PAD_STEP, SCREEN_Y-PAD_H).
  - Both buttons or neither: pos unchanged.
  - Saturation is computed in AW+1 bits to avoid underflow wrap.
- Latency: frame_tick in IDLE at cycle N -> UPDATE at N+1 -> first px_wr at N+2. Busy window is 1+2*SCREEN_Y cycles (241).
- Buttons are sampled only in the UPDATE cycle.
- frame_tick while busy=1 is ignored, not queued.
- rst asserted in any state aborts the current operation: px_wr=0 the next cycle, and positions return to centre. The full clear is redone after release.

Optional Feature:
- Macro: PONG_FB_SKIP_UNCHANGED_EN.
- Defined:
  - UPDATE records per-paddle changed flags.
  - A paddle whose position did not change skips its DRAW state.
  - If neither paddle changed, UPDATE goes directly to IDLE with no writes (busy high for 1 cycle).
  - The post-reset DRAW_A and DRAW_B always run.
- Undefined: both columns are repainted on every frame tick, as described above.

Test Plan:
- Reset for 3 cycles, release -> 21120 consecutive px_wr cycles, addr 0..21119, data=000. Then 120 writes at addr 4+176*y, data 100 for y=48..71, else 000. Then 120 writes at addr 171+176*y with 001 for y=48..71. busy falls 1 cycle after the last write.
- btn_up_a=1 held, frame_tick pulse -> first write 2 cycles later. Column A shows 100 for y=46..69 and 000 at y=70,71. Column B is unchanged at 48..71.
- btn_up_b held for 30 frame ticks -> pos_b saturates at 0: rows 0..23 are 001 and row 24 is 000, no wrap. btn_dn_a held for 40 ticks -> pos_a=96, rows 96..119 are 100.
- btn_up_a and btn_dn_a both high on a tick -> pos_a stays 48. A second frame_tick injected mid-DRAW_A -> exactly 241 busy cycles, no extra UPDATE.
- rst pulse in the middle of DRAW_B -> px_wr=0 the next cycle, then a full 21120-cycle clear restarts from addr 0 and paddles return to 48.
- With PONG_FB_SKIP_UNCHANGED_EN and no buttons pressed -> frame_tick gives busy for 1 cycle and zero px_wr. Pressing btn_dn_b only -> exactly 120 writes, all in column 171.
